gol_sequencer: RTL and testbench

- Central controller for the Game of Life engines: init/randomize, next-state compute, copy-back.
- Decides when a generation advances (timer, single-step, randomize request), aligns starts to frame boundaries, and runs each engine through a req/done handshake.
- Counts generations and flags hung engines via a watchdog.
- Sits between the top-level ui_in controls / hvsync generator and the three board-state engines.

---
 rtl/gol_pkg.sv | 20 ++
 rtl/gol_interval_timer.sv | 52 +++++
 rtl/gol_sequencer.sv | 149 ++++++++++++++
 tb/tb_gol_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life engine controller: sequencer state
// encodings, board geometry and default timing constants.
package gol_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_COPY   = 3'd4
  } state_e;

  localparam int logWIDTH   = 6;
  localparam int logHEIGHT  = 5;
  localparam int BOARD_SIZE = 1 << (logWIDTH + logHEIGHT);

  localparam int CLOCK_FREQ              = 24000000;
  localparam int DEFAULT_UPDATE_INTERVAL = 2400000;

endpackage

// File: rtl/gol_interval_timer.sv
// Generation pacing: saturating interval timer scaled by speed, vsync rising
// edge detector and the frame-aligned trigger for the sequencer FSM.
module gol_interval_timer
  import gol_pkg::*;
#(
  parameter int UPDATE_INTERVAL = DEFAULT_UPDATE_INTERVAL,
  parameter int TIMER_W         = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic       vsync,
  input  logic       run,
  input  logic       in_idle,
  input  logic       step_pend,
  output logic       trigger
);

  localparam logic [TIMER_W-1:0] INTERVAL_BASE = TIMER_W'(UPDATE_INTERVAL);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] interval;
  logic               vsync_q;
  logic               vs_rise;
  logic               expired;

  // IDLE is only ever left through a trigger, so the trigger doubles as the
  // clear for the next interval.
  always_comb begin
    interval = INTERVAL_BASE >> speed;
    expired  = (timer_q >= interval);
    vs_rise  = vsync & ~vsync_q;
    trigger  = in_idle & vs_rise & ((run & expired) | (~run & step_pend));
    timer_d  = timer_q;
    if (trigger) begin
      timer_d = '0;
    end else if (in_idle && run && !expired) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      vsync_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      vsync_q <= vsync;
    end
  end

endmodule

// File: rtl/gol_sequencer.sv
// Central Game of Life controller: sequences INIT / UPDATE / COPY engines via
// req/done handshakes, counts generations and watchdogs stuck engines.
module gol_sequencer
  import gol_pkg::*;
#(
  parameter int UPDATE_INTERVAL = DEFAULT_UPDATE_INTERVAL,
  parameter int TIMER_W         = 24,
  parameter int WATCHDOG        = 4096,
  parameter int GEN_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             randomize,
  input  logic [1:0]       speed,
  input  logic             vsync,
  output logic             init_req,
  input  logic             init_done,
  output logic             update_req,
  input  logic             update_done,
  output logic             copy_req,
  input  logic             copy_done,
  output logic             busy,
  output logic [GEN_W-1:0] generation,
  output logic             wd_error,
  output logic [2:0]       state
);

  localparam int             WD_W    = $clog2(WATCHDOG) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);

  state_e             state_q, state_d;
  logic               step_pend_q, step_pend_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               wd_error_q, wd_error_d;
  logic               init_req_q, init_req_d;
  logic               update_req_q, update_req_d;
  logic               copy_req_q, copy_req_d;
  logic               busy_q, busy_d;
  logic               trigger;
  logic               wd_expired;
  logic               in_engine;

  gol_interval_timer #(
    .UPDATE_INTERVAL (UPDATE_INTERVAL),
    .TIMER_W         (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .speed     (speed),
    .vsync     (vsync),
    .run       (run),
    .in_idle   (state_q == ST_IDLE),
    .step_pend (step_pend_q),
    .trigger   (trigger)
  );

  always_comb begin
    state_d    = state_q;
    gen_d      = gen_q;
    wd_error_d = wd_error_q;
    wd_expired = (wd_cnt_q == WD_LAST);
    in_engine  = (state_q == ST_INIT) || (state_q == ST_UPDATE) || (state_q == ST_COPY);

    // A done pulse wins over a simultaneous watchdog expiry.
    case (state_q)
      ST_BOOT: state_d = ST_INIT;
      ST_INIT: begin
        if (init_done) begin
          state_d = ST_IDLE;
          gen_d   = '0;
        end else if (wd_expired) begin
          state_d    = ST_IDLE;
          wd_error_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (trigger) begin
          state_d = randomize ? ST_INIT : ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (update_done) begin
          state_d = ST_COPY;
        end else if (wd_expired) begin
          state_d    = ST_IDLE;
          wd_error_d = 1'b1;
        end
      end
      ST_COPY: begin
        if (copy_done) begin
          state_d = ST_IDLE;
          gen_d   = gen_q + 1'b1;
        end else if (wd_expired) begin
          state_d    = ST_IDLE;
          wd_error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    step_pend_d = (step_pend_q & ~trigger) | step;

    wd_cnt_d = '0;
    if (state_d == state_q && in_engine) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end

    init_req_d   = (state_d == ST_INIT);
    update_req_d = (state_d == ST_UPDATE);
    copy_req_d   = (state_d == ST_COPY);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      step_pend_q  <= 1'b0;
      wd_cnt_q     <= '0;
      gen_q        <= '0;
      wd_error_q   <= 1'b0;
      init_req_q   <= 1'b0;
      update_req_q <= 1'b0;
      copy_req_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_pend_q  <= step_pend_d;
      wd_cnt_q     <= wd_cnt_d;
      gen_q        <= gen_d;
      wd_error_q   <= wd_error_d;
      init_req_q   <= init_req_d;
      update_req_q <= update_req_d;
      copy_req_q   <= copy_req_d;
      busy_q       <= busy_d;
    end
  end

  assign init_req   = init_req_q;
  assign update_req = update_req_q;
  assign copy_req   = copy_req_q;
  assign busy       = busy_q;
  assign generation = gen_q;
  assign wd_error   = wd_error_q;
  assign state      = state_q;

endmodule

// File: tb/tb_gol_sequencer.sv
// Directed bench for gol_sequencer with a short interval and watchdog so every
// path (timer, step, randomize, watchdog, async reset) is reached quickly.
module tb_gol_sequencer;

  localparam int GEN_W = 16;

  localparam logic [31:0] S_BOOT   = 32'd0;
  localparam logic [31:0] S_INIT   = 32'd1;
  localparam logic [31:0] S_IDLE   = 32'd2;
  localparam logic [31:0] S_UPDATE = 32'd3;
  localparam logic [31:0] S_COPY   = 32'd4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             run = 1'b0;
  logic             step = 1'b0;
  logic             randomize = 1'b0;
  logic [1:0]       speed = 2'd0;
  logic             vsync = 1'b0;
  logic             init_req;
  logic             init_done = 1'b0;
  logic             update_req;
  logic             update_done = 1'b0;
  logic             copy_req;
  logic             copy_done = 1'b0;
  logic             busy;
  logic [GEN_W-1:0] generation;
  logic             wd_error;
  logic [2:0]       state;

  int checks = 0;
  int errors = 0;

  gol_sequencer #(
    .UPDATE_INTERVAL (8),
    .TIMER_W         (24),
    .WATCHDOG        (16),
    .GEN_W           (GEN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .step        (step),
    .randomize   (randomize),
    .speed       (speed),
    .vsync       (vsync),
    .init_req    (init_req),
    .init_done   (init_done),
    .update_req  (update_req),
    .update_done (update_done),
    .copy_req    (copy_req),
    .copy_done   (copy_done),
    .busy        (busy),
    .generation  (generation),
    .wd_error    (wd_error),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vsync_rise();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic apply_stimulus(input string what);
    case (what)
      "init_done":   init_done = 1'b1;
      "update_done": update_done = 1'b1;
      "copy_done":   copy_done = 1'b1;
      "step":        step = 1'b1;
      default:       ;
    endcase
    tick();
    init_done   = 1'b0;
    update_done = 1'b0;
    copy_done   = 1'b0;
    step        = 1'b0;
  endtask

  task automatic finish_generation(input logic [31:0] exp_gen);
    apply_stimulus("update_done");
    check_output("gen_copy_state", 32'(state), S_COPY);
    apply_stimulus("copy_done");
    check_output("gen_idle_state", 32'(state), S_IDLE);
    check_output("gen_count", 32'(generation), exp_gen);
  endtask

  initial begin
    $display("[TB] starting gol_sequencer bench");
    #1 rst_n = 1'b0;
    #20;
    check_output("rst_state", 32'(state), S_BOOT);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_init_req", 32'(init_req), 32'd0);
    check_output("rst_gen", 32'(generation), 32'd0);
    check_output("rst_wd_error", 32'(wd_error), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("boot_hold", 32'(state), S_BOOT);
    tick();
    check_output("boot_to_init", 32'(state), S_INIT);
    check_output("init_req_high", 32'(init_req), 32'd1);
    check_output("init_busy", 32'(busy), 32'd1);

    init_done = 1'b1;
    #1;
    check_output("init_req_before_edge", 32'(init_req), 32'd1);
    tick();
    init_done = 1'b0;
    check_output("init_req_dropped", 32'(init_req), 32'd0);
    check_output("init_to_idle", 32'(state), S_IDLE);
    check_output("init_gen_zero", 32'(generation), 32'd0);
    check_output("idle_busy", 32'(busy), 32'd0);

    apply_stimulus("copy_done");
    check_output("stray_done_state", 32'(state), S_IDLE);
    check_output("stray_done_gen", 32'(generation), 32'd0);

    // Free-running: timer long expired when vsync rises.
    run = 1'b1;
    tick(20);
    vsync_rise();
    check_output("run_trigger_state", 32'(state), S_UPDATE);
    check_output("run_update_req", 32'(update_req), 32'd1);
    check_output("run_copy_req_low", 32'(copy_req), 32'd0);
    apply_stimulus("update_done");
    check_output("copy_state", 32'(state), S_COPY);
    check_output("copy_req_high", 32'(copy_req), 32'd1);
    check_output("update_req_low", 32'(update_req), 32'd0);
    apply_stimulus("copy_done");
    check_output("gen1_state", 32'(state), S_IDLE);
    check_output("gen1_count", 32'(generation), 32'd1);
    check_output("gen1_copy_req", 32'(copy_req), 32'd0);

    // vsync while timer is 5 must not trigger; later one after saturation does.
    tick(5);
    vsync_rise();
    check_output("early_vsync_idle", 32'(state), S_IDLE);
    tick(4);
    vsync_rise();
    check_output("late_vsync_update", 32'(state), S_UPDATE);

    // Step latched during UPDATE runs exactly one generation later.
    run = 1'b0;
    apply_stimulus("step");
    check_output("step_in_update", 32'(state), S_UPDATE);
    finish_generation(32'd2);
    vsync_rise();
    check_output("step_trigger", 32'(state), S_UPDATE);
    finish_generation(32'd3);
    for (int i = 0; i < 3; i++) begin
      vsync_rise();
      tick();
      check_output("step_consumed", 32'(state), S_IDLE);
    end
    check_output("step_gen_hold", 32'(generation), 32'd3);

    for (int i = 0; i < 2; i++) begin
      apply_stimulus("step");
      vsync_rise();
      check_output("step_gen_update", 32'(state), S_UPDATE);
      finish_generation(32'd4 + 32'(i));
    end

    // Randomize selects INIT and resets the generation count.
    run = 1'b1;
    randomize = 1'b1;
    tick(9);
    vsync_rise();
    randomize = 1'b0;
    check_output("rand_state", 32'(state), S_INIT);
    check_output("rand_update_req", 32'(update_req), 32'd0);
    check_output("rand_gen_before", 32'(generation), 32'd5);
    apply_stimulus("init_done");
    check_output("rand_idle", 32'(state), S_IDLE);
    check_output("rand_gen_zero", 32'(generation), 32'd0);

    tick(9);
    vsync_rise();
    finish_generation(32'd1);

    // Watchdog: UPDATE held 16 cycles without done.
    tick(9);
    vsync_rise();
    check_output("wd_enter_update", 32'(state), S_UPDATE);
    tick(15);
    check_output("wd_not_yet_state", 32'(state), S_UPDATE);
    check_output("wd_not_yet_flag", 32'(wd_error), 32'd0);
    tick();
    check_output("wd_state_idle", 32'(state), S_IDLE);
    check_output("wd_flag", 32'(wd_error), 32'd1);
    check_output("wd_gen_hold", 32'(generation), 32'd1);
    check_output("wd_update_req", 32'(update_req), 32'd0);

    // speed=3 gives interval 1: a timer of 1 already triggers.
    speed = 2'd3;
    tick();
    vsync_rise();
    speed = 2'd0;
    check_output("speed_trigger", 32'(state), S_UPDATE);
    check_output("wd_sticky", 32'(wd_error), 32'd1);
    apply_stimulus("update_done");
    check_output("pre_reset_copy_req", 32'(copy_req), 32'd1);

    // Asynchronous reset mid-COPY.
    rst_n = 1'b0;
    #1;
    check_output("areset_copy_req", 32'(copy_req), 32'd0);
    check_output("areset_state", 32'(state), S_BOOT);
    check_output("areset_wd_error", 32'(wd_error), 32'd0);
    check_output("areset_gen", 32'(generation), 32'd0);
    check_output("areset_busy", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    check_output("rerun_boot_init", 32'(state), S_INIT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
